fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter QDEPTH, 2, fetch queue entries (power of two, >=2).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 pred_pc  out  32  lookup PC to branch predictor; always equals current fetch PC.
REQ-006 pred_taken  in  1  predictor's taken prediction for pred_pc, same cycle.
REQ-007 pred_target  in  32  predictor's target for pred_pc, same cycle.
REQ-008 imem_req  out  1  instruction fetch request.
REQ-009 imem_addr  out  32  fetch address, word aligned.
REQ-010 imem_ready  in  1  request completes this cycle; imem_rdata valid.
REQ-011 imem_rdata  in  32  fetched instruction.
REQ-012 flush  in  1  mispredict redirect from mem stage.
REQ-013 flush_pc  in  32  corrected PC, valid with flush.
REQ-014 if_valid  out  1  queue head valid to decode.
REQ-015 if_ready  in  1  decode accepts head.
REQ-016 if_instr, if_pc  out  32 each  head instruction and its PC.
REQ-017 if_predict  out  1, if_pred_target  out  32  prediction carried with head, for mem-stage check.

Function
REQ-018 SHALL hold fetch PC register pc; pred_pc = imem_addr = pc with bits [1:0] = 0.
REQ-019 SHALL implement states FETCH and DRAIN.
REQ-020 FETCH: imem_req = 1 iff queue count < QDEPTH; combinational on registered state only (no path from imem_ready/if_ready).
REQ-021 Once imem_req=1 with an address, SHALL hold req and addr stable until imem_ready=1 (no withdrawal, no address change).
REQ-022 Accept = imem_req & imem_ready: SHALL push {pc, imem_rdata, pred_taken, pred_target} into queue, sampled that cycle.
REQ-023 On accept, next pc = pred_taken ? {pred_target[31:2],2'b00} : pc+4, modulo 2^32 (0xFFFF_FFFC+4 -> 0).
REQ-024 Queue: FIFO, pop when if_valid & if_ready; push and pop same cycle keep count; if_valid = count != 0; head fields registered.
REQ-025 Flush in FETCH with imem_req=0 or imem_ready=1: pc <= {flush_pc[31:2],2'b00}, queue cleared, any data that cycle discarded, stay FETCH.
REQ-026 Flush in FETCH with imem_req=1 and imem_ready=0: SHALL save redirect PC, clear queue, go DRAIN.
REQ-027 DRAIN: keep imem_req=1 with old address; on imem_ready discard data, pc <= saved redirect PC, go FETCH.
REQ-028 Flush during DRAIN: saved redirect PC replaced (latest wins); if imem_ready same cycle, new flush_pc used; queue stays empty.
REQ-029 Flush has priority over push and pop; if_valid = 0 the cycle after any flush.
REQ-030 No push in DRAIN; if_valid = 0 throughout DRAIN.
REQ-031 One outstanding request max; throughput one instruction per cycle when imem_ready=1 and decode drains.

Reset
REQ-032 While rst=1: imem_req=0, if_valid=0, count=0, state=FETCH, pc=RESET_PC, outputs if_* = 0.
REQ-033 rst during DRAIN or with a request pending SHALL abandon it; first cycle after rst falls: imem_req=1, imem_addr=RESET_PC.

Verification
REQ-034 Release rst, imem_ready=1 always, pred_taken=0, if_ready=1 -> addrs 0x0,0x4,0x8; if_pc follows one cycle later.
REQ-035 At pc=0x10 pred_taken=1, pred_target=0x40 -> next imem_addr=0x40; if_predict=1, if_pred_target=0x40 with if_pc=0x10.
REQ-036 if_ready=0, imem_ready=1 -> two pushes, then imem_req=0, addr held at 0x8; if_ready=1 -> req resumes 0x8.
REQ-037 imem_req=1 addr 0x20, imem_ready=0, flush=1 flush_pc=0x100 -> DRAIN, req held at 0x20; imem_ready=1 -> data dropped, next addr 0x100.
REQ-038 flush with imem_ready=1 same cycle, flush_pc=0x203 -> data dropped, queue empty, next addr 0x200.
REQ-039 pc=0xFFFF_FFFC, no prediction -> next addr 0x0000_0000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, single-outstanding imem request, small prediction-carrying
// FIFO to decode, and a DRAIN state that retires an in-flight request after a redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pred_pc,
    input  logic        pred_taken,
    input  logic [31:0] pred_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_predict,
    output logic [31:0] if_pred_target
);

    localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [31:0] AlignMask = 32'hFFFF_FFFC;

    typedef enum logic [0:0] {StFetch, StDrain} state_e;

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     redir_q, redir_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;

    logic [31:0] q_pc     [QDEPTH];
    logic [31:0] q_instr  [QDEPTH];
    logic        q_pred   [QDEPTH];
    logic [31:0] q_target [QDEPTH];

    logic accept, push, pop;

    // Request depends only on registered state; rst gating keeps it low while in reset.
    assign imem_req  = !rst && ((state_q == StDrain) || (count_q < CntW'(QDEPTH)));
    assign imem_addr = pc_q & AlignMask;
    assign pred_pc   = pc_q & AlignMask;
    assign accept    = imem_req && imem_ready;

    assign if_valid       = !rst && (count_q != '0);
    assign if_pc          = if_valid ? q_pc[rptr_q]     : '0;
    assign if_instr       = if_valid ? q_instr[rptr_q]  : '0;
    assign if_predict     = if_valid ? q_pred[rptr_q]   : 1'b0;
    assign if_pred_target = if_valid ? q_target[rptr_q] : '0;
    assign pop            = if_valid && if_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        redir_d = redir_q;
        count_d = count_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        push    = 1'b0;
        unique case (state_q)
            StFetch: begin
                if (flush) begin
                    count_d = '0;
                    wptr_d  = '0;
                    rptr_d  = '0;
                    // An unfinished request must complete before the redirect takes effect.
                    if (imem_req && !imem_ready) begin
                        redir_d = flush_pc & AlignMask;
                        state_d = StDrain;
                    end else begin
                        pc_d = flush_pc & AlignMask;
                    end
                end else begin
                    push = accept;
                    if (accept) begin
                        pc_d = pred_taken ? (pred_target & AlignMask) : pc_q + 32'd4;
                    end
                    if (push) wptr_d = wptr_q + 1'b1;
                    if (pop)  rptr_d = rptr_q + 1'b1;
                    count_d = count_q + CntW'(push) - CntW'(pop);
                end
            end
            StDrain: begin
                if (flush) redir_d = flush_pc & AlignMask;
                if (imem_ready) begin
                    state_d = StFetch;
                    pc_d    = flush ? (flush_pc & AlignMask) : redir_q;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC & AlignMask;
            redir_q <= RESET_PC & AlignMask;
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            redir_q <= redir_d;
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end

    // Storage needs no reset: every read is gated by if_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wptr_q]     <= pc_q & AlignMask;
            q_instr[wptr_q]  <= imem_rdata;
            q_pred[wptr_q]   <= pred_taken;
            q_target[wptr_q] <= pred_target;
        end
    end

endmodule
